// File: rtl/packet_tagger.sv
// Reorder-tag attaching register slice in front of circular_buffer; truncates over-long packets.
// Optional packet/truncation statistics are built when PKT_STATS_EN is defined.
module packet_tagger #(
    parameter int unsigned TAG_WIDTH            = 6,
    parameter int unsigned CIRCULAR_BUFFER_SIZE = 50,
    parameter int unsigned DATA_WIDTH           = 64,
    parameter int unsigned MAX_TDATA_PER_PACKET = 375
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_TDATA,
    input  logic                  s_TLAST,
    input  logic                  s_TVALID,
    output logic                  s_TREADY,
    output logic [DATA_WIDTH-1:0] buffer_TDATA,
    output logic [TAG_WIDTH-1:0]  reorder_tag_in,
    output logic                  buffer_TLAST,
    output logic                  buffer_TVALID,
    input  logic                  buffer_TREADY,
    output logic                  tag_alloc_valid,
    output logic [TAG_WIDTH-1:0]  tag_alloc,
    output logic [31:0]           pkt_count,
    output logic [31:0]           trunc_count
);

    localparam int unsigned BEAT_W = $clog2(MAX_TDATA_PER_PACKET + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_IN_PKT,
        S_DISCARD
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [BEAT_W-1:0]     r_beat_cnt;
    logic [BEAT_W-1:0]     w_beat_num;
    logic [TAG_WIDTH-1:0]  r_tag;
    logic [TAG_WIDTH-1:0]  w_tag_nxt;
    logic [DATA_WIDTH-1:0] r_data;
    logic [TAG_WIDTH-1:0]  r_tag_out;
    logic                  r_last;
    logic                  r_valid;
    logic                  r_alloc_valid;
    logic [TAG_WIDTH-1:0]  r_alloc_tag;
    logic                  w_accept;
    logic                  w_fwd;
    logic                  w_forced;
    logic                  w_last;

    // DISCARD always drains the input, even while the output beat is stalled
    assign s_TREADY = rst && ((r_state == S_DISCARD) || !r_valid || buffer_TREADY);
    assign w_accept = s_TVALID && s_TREADY;

    assign buffer_TDATA    = r_data;
    assign reorder_tag_in  = r_tag_out;
    assign buffer_TLAST    = r_last;
    assign buffer_TVALID   = r_valid;
    assign tag_alloc_valid = r_alloc_valid;
    assign tag_alloc       = r_alloc_tag;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fwd       = w_accept && (r_state != S_DISCARD);
        w_beat_num  = r_beat_cnt + BEAT_W'(1);
        w_forced    = w_fwd && !s_TLAST && (w_beat_num == BEAT_W'(MAX_TDATA_PER_PACKET));
        w_last      = s_TLAST || w_forced;
        w_tag_nxt   = (r_tag == TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1)) ? '0 : r_tag + TAG_WIDTH'(1);
        case (r_state)
            S_IDLE, S_IN_PKT: begin
                if (w_fwd) begin
                    if (w_forced) begin
                        w_state_nxt = S_DISCARD;
                    end else if (s_TLAST) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_IN_PKT;
                    end
                end
            end
            S_DISCARD: begin
                if (w_accept && s_TLAST) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output register slice, tag/beat counters and allocation pulse
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_data        <= '0;
            r_tag_out     <= '0;
            r_last        <= 1'b0;
            r_valid       <= 1'b0;
            r_beat_cnt    <= '0;
            r_tag         <= '0;
            r_alloc_valid <= 1'b0;
            r_alloc_tag   <= '0;
        end else begin
            r_alloc_valid <= w_fwd && (r_state == S_IDLE);
            if (w_fwd && (r_state == S_IDLE)) begin
                r_alloc_tag <= r_tag;
            end
            if (w_fwd) begin
                r_data     <= s_TDATA;
                r_tag_out  <= r_tag;
                r_last     <= w_last;
                r_valid    <= 1'b1;
                r_beat_cnt <= w_last ? '0 : w_beat_num;
                if (w_last) begin
                    r_tag <= w_tag_nxt;
                end
            end else if (buffer_TREADY) begin
                r_valid <= 1'b0;
            end
        end
    end

`ifdef PKT_STATS_EN
    logic        r_forced;
    logic [31:0] r_pkt_count;
    logic [31:0] r_trunc_count;

    // Saturating counters of TLAST beats taken by the buffer
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_forced      <= 1'b0;
            r_pkt_count   <= '0;
            r_trunc_count <= '0;
        end else begin
            if (w_fwd) begin
                r_forced <= w_forced;
            end
            if (r_valid && buffer_TREADY && r_last) begin
                if (r_pkt_count != '1) begin
                    r_pkt_count <= r_pkt_count + 32'd1;
                end
                if (r_forced && (r_trunc_count != '1)) begin
                    r_trunc_count <= r_trunc_count + 32'd1;
                end
            end
        end
    end

    assign pkt_count   = r_pkt_count;
    assign trunc_count = r_trunc_count;
`else
    assign pkt_count   = '0;
    assign trunc_count = '0;
`endif

endmodule

// File: tb/tb_packet_tagger.sv
// Directed bench for packet_tagger (MAX_TDATA_PER_PACKET=4, CIRCULAR_BUFFER_SIZE=50).
module tb_packet_tagger;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] s_TDATA;
    logic        s_TLAST;
    logic        s_TVALID;
    logic        s_TREADY;
    logic [63:0] buffer_TDATA;
    logic [5:0]  reorder_tag_in;
    logic        buffer_TLAST;
    logic        buffer_TVALID;
    logic        buffer_TREADY;
    logic        tag_alloc_valid;
    logic [5:0]  tag_alloc;
    logic [31:0] pkt_count;
    logic [31:0] trunc_count;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    typedef struct {
        logic [63:0] d;
        logic [5:0]  t;
        logic        l;
        int          c;
    } beat_t;

    beat_t       q[$];
    logic [5:0]  aq[$];

    packet_tagger #(
        .TAG_WIDTH(6),
        .CIRCULAR_BUFFER_SIZE(50),
        .DATA_WIDTH(64),
        .MAX_TDATA_PER_PACKET(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_TDATA(s_TDATA),
        .s_TLAST(s_TLAST),
        .s_TVALID(s_TVALID),
        .s_TREADY(s_TREADY),
        .buffer_TDATA(buffer_TDATA),
        .reorder_tag_in(reorder_tag_in),
        .buffer_TLAST(buffer_TLAST),
        .buffer_TVALID(buffer_TVALID),
        .buffer_TREADY(buffer_TREADY),
        .tag_alloc_valid(tag_alloc_valid),
        .tag_alloc(tag_alloc),
        .pkt_count(pkt_count),
        .trunc_count(trunc_count)
    );

    always #5 clk = ~clk;

    // Record every beat the buffer takes and every tag allocation
    always @(posedge clk) begin
        if (rst && buffer_TVALID && buffer_TREADY) begin
            q.push_back('{d: buffer_TDATA, t: reorder_tag_in, l: buffer_TLAST, c: cyc});
        end
        if (rst && tag_alloc_valid) begin
            aq.push_back(tag_alloc);
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Offer one beat starting at a negedge; returns at the negedge after acceptance
    task automatic send(input logic [63:0] d, input logic last);
        bit done = 0;
        s_TDATA  = d;
        s_TLAST  = last;
        s_TVALID = 1'b1;
        for (int i = 0; i < 100 && !done; i++) begin
            #1;
            done = s_TREADY;
            @(negedge clk);
        end
        if (!done) check("send_timeout", 64'd0, 64'd1);
    endtask

    task automatic idle(input int n);
        s_TVALID = 1'b0;
        s_TLAST  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst      = 1'b0;
        s_TVALID = 1'b0;
        s_TLAST  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_beat(input string name, input int idx, input logic [63:0] d,
                              input logic [5:0] t, input logic l);
        if (idx < q.size()) begin
            check({name, "_data"}, q[idx].d, d);
            check({name, "_tag"}, 64'(q[idx].t), 64'(t));
            check({name, "_last"}, 64'(q[idx].l), 64'(l));
        end else begin
            check({name, "_missing"}, 64'(q.size()), 64'(idx + 1));
        end
    endtask

    initial begin
        rst           = 1'b0;
        s_TDATA       = '0;
        s_TLAST       = 1'b0;
        s_TVALID      = 1'b0;
        buffer_TREADY = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_valid", 64'(buffer_TVALID), 64'd0);
        check("rst_last", 64'(buffer_TLAST), 64'd0);
        check("rst_data", buffer_TDATA, 64'd0);
        check("rst_tag", 64'(reorder_tag_in), 64'd0);
        check("rst_alloc_valid", 64'(tag_alloc_valid), 64'd0);
        check("rst_s_ready", 64'(s_TREADY), 64'd0);
        check("rst_pkt_count", 64'(pkt_count), 64'd0);
        check("rst_trunc_count", 64'(trunc_count), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // 3-beat packet, cycle-exact latency and alloc pulse
        s_TVALID = 1'b1; s_TDATA = 64'hA1; s_TLAST = 1'b0;
        @(negedge clk);
        check("p3_b1_valid", 64'(buffer_TVALID), 64'd1);
        check("p3_b1_data", buffer_TDATA, 64'hA1);
        check("p3_b1_tag", 64'(reorder_tag_in), 64'd0);
        check("p3_b1_last", 64'(buffer_TLAST), 64'd0);
        check("p3_alloc_valid", 64'(tag_alloc_valid), 64'd1);
        check("p3_alloc_tag", 64'(tag_alloc), 64'd0);
        s_TDATA = 64'hA2;
        @(negedge clk);
        check("p3_b2_data", buffer_TDATA, 64'hA2);
        check("p3_alloc_once", 64'(tag_alloc_valid), 64'd0);
        s_TDATA = 64'hA3; s_TLAST = 1'b1;
        @(negedge clk);
        check("p3_b3_data", buffer_TDATA, 64'hA3);
        check("p3_b3_last", 64'(buffer_TLAST), 64'd1);
        check("p3_b3_tag", 64'(reorder_tag_in), 64'd0);
        s_TVALID = 1'b0; s_TLAST = 1'b0;
        @(negedge clk);
        check("p3_drained", 64'(buffer_TVALID), 64'd0);
        s_TVALID = 1'b1; s_TDATA = 64'hB1; s_TLAST = 1'b1;
        @(negedge clk);
        check("p1_tag", 64'(reorder_tag_in), 64'd1);
        check("p1_last", 64'(buffer_TLAST), 64'd1);
        check("p1_alloc_valid", 64'(tag_alloc_valid), 64'd1);
        check("p1_alloc_tag", 64'(tag_alloc), 64'd1);
        idle(2);

        // Back-pressure: 4 stalled cycles mid-packet
        q.delete();
        send(64'hC1, 1'b0);
        buffer_TREADY = 1'b0;
        s_TVALID = 1'b1; s_TDATA = 64'hC2; s_TLAST = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("bp_hold_valid", 64'(buffer_TVALID), 64'd1);
            check("bp_hold_data", buffer_TDATA, 64'hC1);
            check("bp_s_ready", 64'(s_TREADY), 64'd0);
            @(negedge clk);
        end
        buffer_TREADY = 1'b1;
        send(64'hC2, 1'b0);
        send(64'hC3, 1'b1);
        idle(2);
        check("bp_count", 64'(q.size()), 64'd3);
        check_beat("bp0", 0, 64'hC1, 6'd2, 1'b0);
        check_beat("bp1", 1, 64'hC2, 6'd2, 1'b0);
        check_beat("bp2", 2, 64'hC3, 6'd2, 1'b1);

        // Reset during beat 2 of a 5-beat packet
        send(64'hD1, 1'b0);
        s_TVALID = 1'b1; s_TDATA = 64'hD2; rst = 1'b0;
        @(negedge clk);
        check("mrst_valid", 64'(buffer_TVALID), 64'd0);
        check("mrst_tag", 64'(reorder_tag_in), 64'd0);
        check("mrst_last", 64'(buffer_TLAST), 64'd0);
        rst = 1'b1;
        idle(1);
        q.delete();
        aq.delete();
        send(64'hE1, 1'b0);
        send(64'hE2, 1'b1);
        idle(2);
        check("mrst_count", 64'(q.size()), 64'd2);
        check_beat("mrst0", 0, 64'hE1, 6'd0, 1'b0);
        check_beat("mrst1", 1, 64'hE2, 6'd0, 1'b1);
        check("mrst_alloc_count", 64'(aq.size()), 64'd1);

        // 51 back-to-back single-beat packets: tags 0..49 then 0
        do_reset();
        q.delete();
        aq.delete();
        for (int i = 0; i < 51; i++) send(64'h1000 + 64'(i), 1'b1);
        idle(2);
        check("wrap_count", 64'(q.size()), 64'd51);
        check("wrap_alloc_count", 64'(aq.size()), 64'd51);
        for (int i = 0; i < 51 && i < q.size() && i < aq.size(); i++) begin
            check("wrap_tag", 64'(q[i].t), 64'(i % 50));
            check("wrap_data", q[i].d, 64'h1000 + 64'(i));
            check("wrap_alloc", 64'(aq[i]), 64'(i % 50));
            if (i > 0) check("wrap_gap", 64'(q[i].c - q[i-1].c), 64'd1);
        end

        // 7-beat packet truncated to 4; beats 5-7 drained while output stalls
        q.delete();
        for (int i = 1; i <= 4; i++) send(64'hF0 + 64'(i), 1'b0);
        buffer_TREADY = 1'b0;
        for (int i = 5; i <= 7; i++) begin
            s_TVALID = 1'b1; s_TDATA = 64'hF0 + 64'(i); s_TLAST = (i == 7);
            #1;
            check("trunc_drain_ready", 64'(s_TREADY), 64'd1);
            @(negedge clk);
        end
        s_TVALID = 1'b0; s_TLAST = 1'b0;
        #1;
        check("trunc_hold_data", buffer_TDATA, 64'hF4);
        check("trunc_hold_last", 64'(buffer_TLAST), 64'd1);
        check("trunc_stall_ready", 64'(s_TREADY), 64'd0);
        @(negedge clk);
        buffer_TREADY = 1'b1;
        idle(1);
        send(64'h77, 1'b1);
        idle(2);
        check("trunc_count_beats", 64'(q.size()), 64'd5);
        check_beat("tr0", 0, 64'hF1, 6'd1, 1'b0);
        check_beat("tr1", 1, 64'hF2, 6'd1, 1'b0);
        check_beat("tr2", 2, 64'hF3, 6'd1, 1'b0);
        check_beat("tr3", 3, 64'hF4, 6'd1, 1'b1);
        check_beat("tr_next", 4, 64'h77, 6'd2, 1'b1);
`ifdef PKT_STATS_EN
        check("stat_pkt", 64'(pkt_count), 64'd53);
        check("stat_trunc", 64'(trunc_count), 64'd1);
`else
        check("stat_pkt_tied", 64'(pkt_count), 64'd0);
        check("stat_trunc_tied", 64'(trunc_count), 64'd0);
`endif

        // Back-to-back 3-beat packets: no bubble across TLAST
        q.delete();
        for (int p = 0; p < 2; p++) begin
            for (int b = 0; b < 3; b++) send(64'h500 + 64'(p * 16 + b), b == 2);
        end
        idle(2);
        check("b2b_count", 64'(q.size()), 64'd6);
        for (int i = 0; i < 6 && i < q.size(); i++) begin
            check("b2b_tag", 64'(q[i].t), 64'(3 + i / 3));
            check("b2b_last", 64'(q[i].l), 64'(i % 3 == 2));
            check("b2b_data", q[i].d, 64'h500 + 64'((i / 3) * 16 + i % 3));
            if (i > 0) check("b2b_gap", 64'(q[i].c - q[i-1].c), 64'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
